// File: rtl/touch_key_event_pkg.sv
// Shared types and default timing for the touch-key gesture classifier.
// Defaults assume a 50 MHz clock.
package touch_key_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_WAIT2,
        ST_PRESS2,
        ST_HOLD
    } gest_state_t;

    localparam int DEF_DEB_CNT  = 1_000_000;   // 20 ms
    localparam int DEF_LONG_CNT = 50_000_000;  // 1 s
    localparam int DEF_DTAP_GAP = 15_000_000;  // 300 ms

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/touch_key_event_if.sv
// Sensor input plus debounced level and gesture strobes.
// slave = the classifier, master = the downstream consumer or driver.
interface touch_key_event_if;
    logic touch_key;
    logic key_level;
    logic tap_pulse;
    logic dtap_pulse;
    logic long_pulse;

    modport master (
        output touch_key,
        input  key_level, tap_pulse, dtap_pulse, long_pulse
    );

    modport slave (
        input  touch_key,
        output key_level, tap_pulse, dtap_pulse, long_pulse
    );
endinterface

// File: rtl/touch_key_event_debounce.sv
// Two-flop synchroniser followed by a counting debouncer.
// key_level follows the raw line only after it has differed for DEB_CNT cycles.
module key_debounce #(
    parameter logic ACTIVE_LVL = 1'b0,
    parameter int   DEB_CNT    = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic touch_key,
    output logic key_level
);
    localparam int DW = $clog2(DEB_CNT);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

    logic [1:0]    sync;
    logic [DW-1:0] deb_cnt;
    logic          raw;

    assign raw = (sync[1] == ACTIVE_LVL);

    // deb_cnt never passes DEB_LAST, so it cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= {2{~ACTIVE_LVL}};
            deb_cnt   <= '0;
            key_level <= 1'b0;
        end else begin
            sync <= {sync[0], touch_key};
            if (raw == key_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                key_level <= raw;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/touch_key_event.sv
// Classifies debounced touches as single tap, double tap or long press and
// emits one-cycle registered strobes for each.
module touch_key_event
    import touch_key_event_pkg::*;
#(
    parameter logic ACTIVE_LVL = 1'b0,
    parameter int   DEB_CNT    = DEF_DEB_CNT,
    parameter int   LONG_CNT   = DEF_LONG_CNT,
    parameter int   DTAP_GAP   = DEF_DTAP_GAP
) (
    input logic              sys_clk,
    input logic              sys_rst,
    touch_key_event_if.slave evt
);
    if (DEB_CNT < 2) begin : g_bad_deb
        $error("touch_key_event: DEB_CNT must be >= 2");
    end
    if (LONG_CNT <= DTAP_GAP) begin : g_bad_long
        $error("touch_key_event: LONG_CNT must exceed DTAP_GAP");
    end

    localparam int GW = $clog2(max_int(LONG_CNT, DTAP_GAP));
    localparam logic [GW-1:0] LONG_LAST = GW'(LONG_CNT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(DTAP_GAP - 1);

    gest_state_t   state, state_next;
    logic [GW-1:0] gest_cnt;
    logic          key_level, key_d, press, rel;
    logic          tap_hit, dtap_hit, long_hit;
    logic          tap_next, dtap_next, long_next;

    key_debounce #(
        .ACTIVE_LVL (ACTIVE_LVL),
        .DEB_CNT    (DEB_CNT)
    ) u_deb (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .touch_key (evt.touch_key),
        .key_level (key_level)
    );

    assign press = key_level & ~key_d;
    assign rel   = ~key_level & key_d;

    // A press arriving on the gap-timeout cycle is still taken as the second tap.
    always_comb begin
        state_next = state;
        tap_next   = 1'b0;
        dtap_next  = 1'b0;
        long_next  = 1'b0;
        case (state)
            ST_IDLE:   if (press) state_next = ST_PRESS1;
            ST_PRESS1: begin
                if (rel) begin
                    state_next = ST_WAIT2;
                end else if (gest_cnt == LONG_LAST) begin
                    long_next  = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_WAIT2: begin
                if (press) begin
                    state_next = ST_PRESS2;
                end else if (gest_cnt == GAP_LAST) begin
                    tap_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (rel) begin
                    dtap_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_HOLD:   if (rel) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            gest_cnt <= '0;
            key_d    <= 1'b0;
            tap_hit  <= 1'b0;
            dtap_hit <= 1'b0;
            long_hit <= 1'b0;
        end else begin
            state    <= state_next;
            key_d    <= key_level;
            tap_hit  <= tap_next;
            dtap_hit <= dtap_next;
            long_hit <= long_next;
            if (state_next != state)
                gest_cnt <= '0;
            else if (gest_cnt != '1)
                gest_cnt <= gest_cnt + 1'b1;
        end
    end

    assign evt.key_level  = key_level;
    assign evt.tap_pulse  = tap_hit;
    assign evt.dtap_pulse = dtap_hit;
    assign evt.long_pulse = long_hit;
endmodule
